// File: rtl/montgomery_shift_sched.sv
`default_nettype none
// ============================================================================
//  Module   : montgomery_shift_sched
//  Function : Round-robin scheduler sharing one fixed-latency montgomery_shift
//             datapath among NREQ requesters. Per-requester modulus-shape
//             table, in-order tag pipe for result routing, per-requester
//             in-flight counters.
//  Revision : 1.0 - initial release
// ============================================================================
module montgomery_shift_sched #(
   parameter int NREQ    = 4,
   parameter int LOGQ    = 32,
   parameter int LOGQH   = 15,
   parameter int LOGL1   = 4,
   parameter int LOGL2   = 4,
   parameter int LOGL3   = 4,
   parameter int CORRECT = 1,
   parameter int DP_LAT  = 5,
   parameter int CNT_W   = 4,
   localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int LOGT   = (CORRECT != 0) ? LOGQ : LOGQ + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*2*LOGQ-1:0] req_C,
   input  logic                   cfg_we,
   input  logic [IDX_W-1:0]       cfg_idx,
   input  logic [LOGQH-1:0]       cfg_qH,
   input  logic [LOGL1-1:0]       cfg_L1,
   input  logic [LOGL2-1:0]       cfg_L2,
   input  logic [LOGL3-1:0]       cfg_L3,
   output logic                   cfg_ack,
   output logic [2*LOGQ-1:0]      dp_C,
   output logic [LOGQH-1:0]       dp_qH,
   output logic [LOGL1-1:0]       dp_L1,
   output logic [LOGL2-1:0]       dp_L2,
   output logic [LOGL3-1:0]       dp_L3,
   input  logic [LOGT-1:0]        dp_T,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [LOGT-1:0]        rsp_T,
   output logic                   idle
);

   localparam int OPW  = 2 * LOGQ;
   localparam int CFGW = LOGQH + LOGL1 + LOGL2 + LOGL3;
   localparam int SW   = IDX_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // state
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q [NREQ];
   logic [CNT_W-1:0] cnt_d [NREQ];
   logic [CFGW-1:0]  tbl_q [NREQ];
   logic [CFGW-1:0]  tbl_d [NREQ];
   logic [OPW-1:0]   dp_c_q, dp_c_d;
   logic [CFGW-1:0]  dp_cfg_q, dp_cfg_d;
   logic [DP_LAT:0]  tv_q, tv_d;
   logic [IDX_W-1:0] tag_q [DP_LAT+1];
   logic [IDX_W-1:0] tag_d [DP_LAT+1];
   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [LOGT-1:0]  rsp_t_q, rsp_t_d;

   // arbitration
   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  grant;
   logic [IDX_W-1:0] gidx;
   logic             hs;
   logic [SW-1:0]    arb_sum;
   logic [IDX_W-1:0] arb_idx;
   logic             idx_ok;

   // Non-power-of-two NREQ leaves cfg_idx codes with no table entry behind them.
   if ((1 << IDX_W) == NREQ) begin : g_idx_full
      assign idx_ok = 1'b1;
   end else begin : g_idx_part
      assign idx_ok = (cfg_idx < IDX_W'(NREQ));
   end

   // Round-robin pick starting at the pointer; saturated requesters are skipped.
   always_comb begin
      elig    = '0;
      grant   = '0;
      gidx    = '0;
      hs      = 1'b0;
      arb_sum = '0;
      arb_idx = '0;
      for (int r = 0; r < NREQ; r++) begin
         elig[r] = req_valid[r] && (cnt_q[r] != CNT_MAX);
      end
      for (int i = 0; i < NREQ; i++) begin
         arb_sum = {1'b0, ptr_q} + SW'(i);
         if (arb_sum >= SW'(NREQ)) begin
            arb_sum = arb_sum - SW'(NREQ);
         end
         arb_idx = arb_sum[IDX_W-1:0];
         if (!hs && rst_n && elig[arb_idx]) begin
            hs             = 1'b1;
            grant[arb_idx] = 1'b1;
            gidx           = arb_idx;
         end
      end
   end

   // Config write only lands on an entry with nothing issued, pending or granted.
   always_comb begin
      cfg_ack = 1'b0;
      if (cfg_we && rst_n && idx_ok && (cnt_q[cfg_idx] == '0) &&
          !req_valid[cfg_idx] && !grant[cfg_idx]) begin
         cfg_ack = 1'b1;
      end
   end

   // Next-state for pointer, table, datapath operand, tag pipe, counters, response.
   always_comb begin
      ptr_d    = ptr_q;
      dp_c_d   = dp_c_q;
      dp_cfg_d = dp_cfg_q;
      tv_d     = {tv_q[DP_LAT-1:0], hs};
      tag_d[0] = gidx;
      for (int s = 1; s <= DP_LAT; s++) begin
         tag_d[s] = tag_q[s-1];
      end
      for (int r = 0; r < NREQ; r++) begin
         tbl_d[r] = tbl_q[r];
         cnt_d[r] = cnt_q[r] + CNT_W'(grant[r]) - CNT_W'(rsp_valid_q[r]);
         if (grant[r]) begin
            dp_c_d   = req_C[r*OPW +: OPW];
            dp_cfg_d = tbl_q[r];
         end
      end
      if (cfg_ack) begin
         tbl_d[cfg_idx] = {cfg_qH, cfg_L1, cfg_L2, cfg_L3};
      end
      if (hs) begin
         ptr_d = (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);
      end
      rsp_valid_d = '0;
      for (int r = 0; r < NREQ; r++) begin
         rsp_valid_d[r] = tv_q[DP_LAT] && (tag_q[DP_LAT] == IDX_W'(r));
      end
      rsp_t_d = dp_T;
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         dp_c_q      <= '0;
         dp_cfg_q    <= '0;
         tv_q        <= '0;
         rsp_valid_q <= '0;
         rsp_t_q     <= '0;
         for (int s = 0; s <= DP_LAT; s++) begin
            tag_q[s] <= '0;
         end
         for (int r = 0; r < NREQ; r++) begin
            cnt_q[r] <= '0;
            tbl_q[r] <= '0;
         end
      end else begin
         ptr_q       <= ptr_d;
         dp_c_q      <= dp_c_d;
         dp_cfg_q    <= dp_cfg_d;
         tv_q        <= tv_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_t_q     <= rsp_t_d;
         for (int s = 0; s <= DP_LAT; s++) begin
            tag_q[s] <= tag_d[s];
         end
         for (int r = 0; r < NREQ; r++) begin
            cnt_q[r] <= cnt_d[r];
            tbl_q[r] <= tbl_d[r];
         end
      end
   end

   // Idle when nothing is in flight and nobody is asking.
   always_comb begin
      idle = (req_valid == '0);
      for (int r = 0; r < NREQ; r++) begin
         if (cnt_q[r] != '0) begin
            idle = 1'b0;
         end
      end
   end

   assign req_ready = grant;
   assign dp_C      = dp_c_q;
   assign {dp_qH, dp_L1, dp_L2, dp_L3} = dp_cfg_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_T     = rsp_t_q;

endmodule
`default_nettype wire

// File: tb/tb_montgomery_shift_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_montgomery_shift_sched
//  Function : Directed self-checking bench for montgomery_shift_sched with a
//             behavioural fixed-latency datapath stand-in.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_montgomery_shift_sched;

   localparam int NREQ   = 4;
   localparam int LOGQ   = 32;
   localparam int DP_LAT = 5;
   localparam int CNT_W  = 2;
   localparam int LAT    = DP_LAT + 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req_valid = '0;
   logic [3:0]    req_ready;
   logic [255:0]  req_C;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_idx = '0;
   logic [14:0]   cfg_qH = '0;
   logic [3:0]    cfg_L1 = '0, cfg_L2 = '0, cfg_L3 = '0;
   logic          cfg_ack;
   logic [63:0]   dp_C;
   logic [14:0]   dp_qH;
   logic [3:0]    dp_L1, dp_L2, dp_L3;
   logic [31:0]   dp_T;
   logic [3:0]    rsp_valid;
   logic [31:0]   rsp_T;
   logic          idle;

   logic [63:0]   opnd  [4];
   logic [26:0]   cfg_m [4];

   typedef struct {
      logic [3:0]  oh;
      logic [31:0] t;
      int          cyc;
   } exp_t;
   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rsp_cnt [4];
   int snap    [4];

   montgomery_shift_sched #(
      .NREQ(NREQ), .LOGQ(LOGQ), .LOGQH(15), .LOGL1(4), .LOGL2(4), .LOGL3(4),
      .CORRECT(1), .DP_LAT(DP_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_C(req_C),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_qH(cfg_qH),
      .cfg_L1(cfg_L1), .cfg_L2(cfg_L2), .cfg_L3(cfg_L3), .cfg_ack(cfg_ack),
      .dp_C(dp_C), .dp_qH(dp_qH), .dp_L1(dp_L1), .dp_L2(dp_L2), .dp_L3(dp_L3),
      .dp_T(dp_T), .rsp_valid(rsp_valid), .rsp_T(rsp_T), .idle(idle)
   );

   for (genvar g = 0; g < 4; g++) begin : g_pack
      assign req_C[g*64 +: 64] = opnd[g];
   end

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in datapath: deterministic function of operand and config, DP_LAT deep.
   function automatic logic [31:0] model_t(input logic [63:0] c, input logic [26:0] cfg);
      return c[31:0] + c[63:32] + {5'b0, cfg};
   endfunction

   logic [31:0] dp_pipe [DP_LAT];
   always @(posedge clk) begin
      dp_pipe[0] <= model_t(dp_C, {dp_qH, dp_L1, dp_L2, dp_L3});
      for (int i = 1; i < DP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
   end
   assign dp_T = dp_pipe[DP_LAT-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Let combinational outputs settle and log any handshake into the scoreboard.
   task automatic settle();
      exp_t e;
      #1;
      for (int r = 0; r < 4; r++) begin
         if (req_ready[r] && req_valid[r]) begin
            e.oh  = 4'b0001 << r;
            e.t   = model_t(opnd[r], cfg_m[r]);
            e.cyc = cyc;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #2;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // Result monitor: order, routing, value and latency.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid != 4'b0) begin
         if (exp_q.size() == 0) begin
            chk("spurious_rsp", 64'(rsp_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(e.oh));
            chk("rsp_T", 64'(rsp_T), 64'(e.t));
            chk("rsp_lat", 64'(cyc - e.cyc), 64'(LAT));
            for (int r = 0; r < 4; r++) if (rsp_valid[r]) rsp_cnt[r]++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int r = 0; r < 4; r++) begin
         opnd[r] = '0; cfg_m[r] = '0; rsp_cnt[r] = 0; snap[r] = 0;
      end

      // ---------------- reset state
      repeat (2) @(negedge clk);
      settle();
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_T", 64'(rsp_T), 64'd0);
      chk("rst_dp_C", dp_C, 64'd0);
      chk("rst_dp_qH", 64'(dp_qH), 64'd0);
      chk("rst_cfg_ack", 64'(cfg_ack), 64'd0);
      chk("rst_idle", 64'(idle), 64'd1);

      // ---------------- single op through requester 0
      @(negedge clk);
      rst_n = 1'b1;
      cfg_we = 1'b1; cfg_idx = 2'd0;
      cfg_qH = 15'h4078; cfg_L1 = 4'd8; cfg_L2 = 4'd4; cfg_L3 = 4'd1;
      settle();
      chk("cfg0_ack", 64'(cfg_ack), 64'd1);
      cfg_m[0] = {15'h4078, 4'd8, 4'd4, 4'd1};
      @(negedge clk);
      cfg_we = 1'b0;
      opnd[0] = 64'h0000_0001_0000_0000;
      req_valid = 4'b0001;
      settle();
      chk("t1_ready", 64'(req_ready), 64'b0001);
      @(negedge clk);
      req_valid = 4'b0000;
      settle();
      chk("t1_dp_C", dp_C, 64'h0000_0001_0000_0000);
      chk("t1_dp_qH", 64'(dp_qH), 64'h4078);
      chk("t1_dp_L1", 64'(dp_L1), 64'd8);
      chk("t1_dp_L3", 64'(dp_L3), 64'd1);
      chk("t1_busy", 64'(idle), 64'd0);
      @(negedge clk);
      opnd[0] = 64'd0;
      req_valid = 4'b0001;
      settle();
      @(negedge clk);
      req_valid = 4'b0000;
      drain();

      // ---------------- all four requesters, 12 cycles (pointer sits at 1)
      for (int r = 0; r < 4; r++) snap[r] = rsp_cnt[r];
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         req_valid = 4'b1111;
         for (int r = 0; r < 4; r++) opnd[r] = {32'(r + 1), 32'(i * 16)};
         settle();
         chk("rr_grant", 64'(req_ready), 64'(4'b0001 << ((1 + i) % 4)));
      end
      @(negedge clk);
      req_valid = 4'b0000;
      repeat (6) @(negedge clk);
      #1;
      chk("rr_busy_last", 64'(idle), 64'd0);
      @(negedge clk);
      #1;
      chk("rr_idle", 64'(idle), 64'd1);
      for (int r = 0; r < 4; r++) chk("rr_count", 64'(rsp_cnt[r] - snap[r]), 64'd3);
      drain();

      // ---------------- config refused while requester 2 is busy
      @(negedge clk);
      req_valid = 4'b0100;
      opnd[2] = 64'h0000_0005_0000_0007;
      cfg_we = 1'b1; cfg_idx = 2'd2;
      cfg_qH = 15'h0123; cfg_L1 = 4'd9; cfg_L2 = 4'd2; cfg_L3 = 4'd3;
      settle();
      chk("cfg_vld_ready", 64'(req_ready), 64'b0100);
      chk("cfg_vld_ack", 64'(cfg_ack), 64'd0);
      @(negedge clk);
      req_valid = 4'b0000;
      settle();
      chk("cfg_busy_ack", 64'(cfg_ack), 64'd0);
      repeat (6) @(negedge clk);
      settle();
      chk("cfg_rsp_cycle_ack", 64'(cfg_ack), 64'd0);
      chk("cfg_rsp_cycle_vld", 64'(rsp_valid), 64'b0100);
      @(negedge clk);
      settle();
      chk("cfg_free_ack", 64'(cfg_ack), 64'd1);
      cfg_m[2] = {15'h0123, 4'd9, 4'd2, 4'd3};
      @(negedge clk);
      cfg_we = 1'b0;
      req_valid = 4'b0100;
      opnd[2] = 64'h0000_0010_0000_0020;
      settle();
      @(negedge clk);
      req_valid = 4'b0000;
      settle();
      chk("cfg_new_L1", 64'(dp_L1), 64'd9);
      drain();

      // ---------------- in-flight counter saturation on requester 1
      @(negedge clk);
      req_valid = 4'b0010;
      opnd[1] = 64'h0000_0003_0000_0004;
      for (int j = 0; j < 9; j++) begin
         settle();
         chk("sat_ready", 64'(req_ready), (j < 3 || j == 8) ? 64'b0010 : 64'd0);
         @(negedge clk);
      end
      req_valid = 4'b0000;
      drain();

      // ---------------- reset with three ops in flight
      @(negedge clk);
      req_valid = 4'b0111;
      repeat (3) begin
         settle();
         @(negedge clk);
      end
      req_valid = 4'b0000;
      rst_n = 1'b0;
      exp_q.delete();
      for (int r = 0; r < 4; r++) cfg_m[r] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < LAT; k++) begin
         #1;
         chk("rst_no_rsp", 64'(rsp_valid), 64'd0);
         @(negedge clk);
      end
      #1;
      chk("rst_idle_after", 64'(idle), 64'd1);
      chk("rst_dp_C_after", dp_C, 64'd0);

      // ---------------- sparse traffic on requester 3
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         req_valid = 4'b1000;
         opnd[3] = 64'hA000_0000_0000_0000 + 64'(j * 3 + 1);
         settle();
         chk("sparse_ready", 64'(req_ready), 64'b1000);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_valid = 4'b0000;
            settle();
            chk("sparse_dp_hold", dp_C, 64'hA000_0000_0000_0000 + 64'(j * 3 + 1));
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
